// File: rtl/rr_arb_2to1.sv
// Two-input round-robin stream arbiter with packet-locked grants and one
// registered output stage; sel is the registered grant driving the 2:1 mux.
module rr_arb_2to1 #(
  parameter int DATA_W    = 8,
  parameter bit LOCK_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  input  logic              y_ready,
  output logic              sel,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_A = 2'd1;
  localparam logic [1:0] GRANT_B = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       prio;
  logic       prio_nxt;
  logic       load;
  logic       a_acc;
  logic       b_acc;

  // The output register can take a beat when empty or emptying this cycle.
  assign load    = !y_valid || y_ready;
  assign a_ready = (state == GRANT_A) && load;
  assign b_ready = (state == GRANT_B) && load;
  assign busy    = (state != IDLE);
  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    case (state)
      IDLE: begin
        if (a_valid && b_valid) state_nxt = prio ? GRANT_B : GRANT_A;
        else if (a_valid)       state_nxt = GRANT_A;
        else if (b_valid)       state_nxt = GRANT_B;
      end
      GRANT_A: begin
        if (a_acc && (a_last || !LOCK_LAST)) begin
          prio_nxt = 1'b1;
          if (b_valid)      state_nxt = GRANT_B;
          else if (a_valid) state_nxt = GRANT_A;
          else              state_nxt = IDLE;
        end
      end
      GRANT_B: begin
        if (b_acc && (b_last || !LOCK_LAST)) begin
          prio_nxt = 1'b0;
          if (a_valid)      state_nxt = GRANT_A;
          else if (b_valid) state_nxt = GRANT_B;
          else              state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sel follows the grant but keeps its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      if (state_nxt == GRANT_A)      sel <= 1'b0;
      else if (state_nxt == GRANT_B) sel <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
    end else if (a_acc) begin
      y_valid <= 1'b1;
      y_data  <= a_data;
      y_last  <= a_last;
    end else if (b_acc) begin
      y_valid <= 1'b1;
      y_data  <= b_data;
      y_last  <= b_last;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_2to1.sv
// Bench for rr_arb_2to1: a packet-level arbiter model checked every cycle on a
// locked (k=0) and a per-beat (k=1) instance, plus directed literal sequences.
module tb_rr_arb_2to1;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         av[2], al[2], ar[2], bv[2], bl[2], br[2];
  logic [W-1:0] ad[2], bd[2], yd[2];
  logic         yv[2], yl[2], yr[2], sl[2], bz[2];

  rr_arb_2to1 #(.DATA_W(W), .LOCK_LAST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(av[0]), .a_data(ad[0]), .a_last(al[0]), .a_ready(ar[0]),
    .b_valid(bv[0]), .b_data(bd[0]), .b_last(bl[0]), .b_ready(br[0]),
    .y_valid(yv[0]), .y_data(yd[0]), .y_last(yl[0]), .y_ready(yr[0]),
    .sel(sl[0]), .busy(bz[0])
  );

  rr_arb_2to1 #(.DATA_W(W), .LOCK_LAST(1'b0)) dut_nl (
    .clk(clk), .rst_n(rst_n),
    .a_valid(av[1]), .a_data(ad[1]), .a_last(al[1]), .a_ready(ar[1]),
    .b_valid(bv[1]), .b_data(bd[1]), .b_last(bl[1]), .b_ready(br[1]),
    .y_valid(yv[1]), .y_data(yd[1]), .y_last(yl[1]), .y_ready(yr[1]),
    .sel(sl[1]), .busy(bz[1])
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Pending source beats {last,data}; front entry is presented until taken.
  logic [8:0] qa0[$], qb0[$], qa1[$], qb1[$];
  logic [8:0] logd0[$], logd1[$], expq[$];
  int         logc0[$], logc1[$];

  // Model: owner -1 = nobody granted, 0 = A, 1 = B.
  int         m_own[2];
  bit         m_prio[2], m_sel[2], m_yv[2], m_yl[2];
  logic [7:0] m_yd[2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void drive();
    av[0] = qa0.size() != 0; {al[0], ad[0]} = av[0] ? qa0[0] : 9'h0;
    bv[0] = qb0.size() != 0; {bl[0], bd[0]} = bv[0] ? qb0[0] : 9'h0;
    av[1] = qa1.size() != 0; {al[1], ad[1]} = av[1] ? qa1[0] : 9'h0;
    bv[1] = qb1.size() != 0; {bl[1], bd[1]} = bv[1] ? qb1[0] : 9'h0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_prio[k] = 0; m_sel[k] = 0;
      m_yv[k] = 0; m_yd[k] = 8'h0; m_yl[k] = 0;
    end
  endfunction

  function automatic void model_step(input int k, input bit lock, input bit a_v, input logic [7:0] a_d,
                                     input bit a_l, input bit b_v, input logic [7:0] b_d, input bit b_l,
                                     input bit y_r);
    bit         room, acc, xv, xl, ov;
    int         x, nxt;
    logic [7:0] xd;
    room = !m_yv[k] || y_r;
    acc  = 0;
    nxt  = m_own[k];
    x    = m_own[k];
    if (x < 0) begin
      if (a_v && b_v) nxt = m_prio[k] ? 1 : 0;
      else if (a_v)   nxt = 0;
      else if (b_v)   nxt = 1;
    end else begin
      xv = (x == 0) ? a_v : b_v;
      xd = (x == 0) ? a_d : b_d;
      xl = (x == 0) ? a_l : b_l;
      ov = (x == 0) ? b_v : a_v;
      if (xv && room) begin
        acc = 1; m_yv[k] = 1; m_yd[k] = xd; m_yl[k] = xl;
        if (xl || !lock) begin
          m_prio[k] = (x == 0);
          nxt = ov ? 1 - x : x;
        end
      end
    end
    if (!acc && m_yv[k] && y_r) m_yv[k] = 0;
    if (nxt >= 0) m_sel[k] = (nxt == 1);
    m_own[k] = nxt;
  endfunction

  // Sampling at the active edge: log output handshakes, retire taken beats, advance model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc++;
      if (yv[0] && yr[0]) begin logd0.push_back({yl[0], yd[0]}); logc0.push_back(cyc); end
      if (yv[1] && yr[1]) begin logd1.push_back({yl[1], yd[1]}); logc1.push_back(cyc); end
      if (av[0] && ar[0]) void'(qa0.pop_front());
      if (bv[0] && br[0]) void'(qb0.pop_front());
      if (av[1] && ar[1]) void'(qa1.pop_front());
      if (bv[1] && br[1]) void'(qb1.pop_front());
      model_step(0, 1'b1, av[0], ad[0], al[0], bv[0], bd[0], bl[0], yr[0]);
      model_step(1, 1'b0, av[1], ad[1], al[1], bv[1], bd[1], bl[1], yr[1]);
    end
  end

  initial begin
    drive();
    forever begin
      @(negedge clk);
      drive();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          string nm;
          nm = (k == 0) ? "lock_" : "beat_";
          checkOutput({nm, "y_valid"}, yv[k], m_yv[k]);
          if (m_yv[k]) begin
            checkOutput({nm, "y_data"}, yd[k], m_yd[k]);
            checkOutput({nm, "y_last"}, yl[k], m_yl[k]);
          end
          checkOutput({nm, "sel"}, sl[k], m_sel[k]);
          checkOutput({nm, "busy"}, bz[k], m_own[k] >= 0);
          checkOutput({nm, "a_ready"}, ar[k], (m_own[k] == 0) && (!m_yv[k] || yr[k]));
          checkOutput({nm, "b_ready"}, br[k], (m_own[k] == 1) && (!m_yv[k] || yr[k]));
        end
      end
    end
  end

  task automatic clear_all();
    qa0.delete(); qb0.delete(); qa1.delete(); qb1.delete();
    logd0.delete(); logd1.delete(); logc0.delete(); logc1.delete();
  endtask

  task automatic restart();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_all();
    yr[0] = 1'b1; yr[1] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int k, input bit to_b, input logic [7:0] d, input bit last);
    if (k == 0 && !to_b) qa0.push_back({last, d});
    if (k == 0 &&  to_b) qb0.push_back({last, d});
    if (k == 1 && !to_b) qa1.push_back({last, d});
    if (k == 1 &&  to_b) qb1.push_back({last, d});
  endtask

  task automatic wait_log(input int k, input int n, input string name);
    int i;
    i = 0;
    while (((k == 0) ? logd0.size() : logd1.size()) < n && i < 300) begin
      @(posedge clk); #1;
      i++;
    end
    if (i >= 300) checkOutput({name, "_timeout"}, (k == 0) ? logd0.size() : logd1.size(), n);
  endtask

  task automatic check_log(input int k, input string name, input bit consec);
    int n;
    n = (k == 0) ? logd0.size() : logd1.size();
    checkOutput({name, "_count"}, n, expq.size());
    for (int i = 0; i < expq.size() && i < n; i++) begin
      checkOutput($sformatf("%s_beat%0d", name, i), (k == 0) ? logd0[i] : logd1[i], expq[i]);
      if (consec)
        checkOutput($sformatf("%s_cycle%0d", name, i),
                    (k == 0) ? logc0[i] - logc0[0] : logc1[i] - logc1[0], i);
    end
  endtask

  initial begin
    yr[0] = 1'b1; yr[1] = 1'b1;

    // Reset held with both sources requesting.
    applyStimulus(0, 0, 8'h5a, 1); applyStimulus(0, 1, 8'h5b, 1);
    @(negedge clk); @(negedge clk); #3;
    checkOutput("t1_y_valid", yv[0], 0);
    checkOutput("t1_sel", sl[0], 0);
    checkOutput("t1_a_ready", ar[0], 0);
    checkOutput("t1_b_ready", br[0], 0);
    checkOutput("t1_busy", bz[0], 0);
    @(posedge clk); #1;
    clear_all();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // A-only three-beat packet.
    restart();
    applyStimulus(0, 0, 8'h11, 0); applyStimulus(0, 0, 8'h22, 0); applyStimulus(0, 0, 8'h33, 1);
    wait_log(0, 3, "t2");
    expq.delete(); expq.push_back(9'h011); expq.push_back(9'h022); expq.push_back(9'h133);
    check_log(0, "t2", 1);
    checkOutput("t2_sel", sl[0], 0);

    // Contention from idle, then alternating packets with no bubble.
    restart();
    applyStimulus(0, 0, 8'h31, 0); applyStimulus(0, 0, 8'h32, 1); applyStimulus(0, 0, 8'h35, 1);
    applyStimulus(0, 1, 8'h41, 0); applyStimulus(0, 1, 8'h42, 1); applyStimulus(0, 1, 8'h45, 1);
    wait_log(0, 6, "t3");
    expq.delete();
    expq.push_back(9'h031); expq.push_back(9'h132); expq.push_back(9'h041);
    expq.push_back(9'h142); expq.push_back(9'h135); expq.push_back(9'h145);
    check_log(0, "t3", 1);
    checkOutput("t3_sel", sl[0], 1);

    // Backpressure in the middle of a packet.
    restart();
    applyStimulus(0, 0, 8'h51, 0); applyStimulus(0, 0, 8'h52, 0);
    applyStimulus(0, 0, 8'h53, 0); applyStimulus(0, 0, 8'h54, 1);
    wait_log(0, 1, "t4a");
    yr[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #3;
      checkOutput("t4_hold_data", yd[0], 8'h52);
      checkOutput("t4_hold_valid", yv[0], 1);
      checkOutput("t4_a_ready", ar[0], 0);
    end
    @(posedge clk); #1;
    yr[0] = 1'b1;
    wait_log(0, 4, "t4b");
    expq.delete();
    expq.push_back(9'h051); expq.push_back(9'h052); expq.push_back(9'h053); expq.push_back(9'h154);
    check_log(0, "t4", 0);

    // Per-beat rearbitration alternates the two streams.
    restart();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 8'hA0 + 8'(i), i == 3);
      applyStimulus(1, 1, 8'hB0 + 8'(i), i == 3);
    end
    wait_log(1, 8, "t5");
    expq.delete();
    for (int i = 0; i < 4; i++) begin
      expq.push_back({i == 3, 8'hA0 + 8'(i)});
      expq.push_back({i == 3, 8'hB0 + 8'(i)});
    end
    check_log(1, "t5", 1);

    // Reset mid-packet on B, then fresh contention favours A.
    restart();
    applyStimulus(0, 1, 8'h61, 0); applyStimulus(0, 1, 8'h62, 0); applyStimulus(0, 1, 8'h63, 1);
    wait_log(0, 1, "t6a");
    rst_n = 1'b0;
    #1;
    checkOutput("t6_y_valid", yv[0], 0);
    checkOutput("t6_y_data", yd[0], 0);
    checkOutput("t6_y_last", yl[0], 0);
    checkOutput("t6_sel", sl[0], 0);
    checkOutput("t6_busy", bz[0], 0);
    checkOutput("t6_b_ready", br[0], 0);
    clear_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 8'h71, 1); applyStimulus(0, 1, 8'h81, 1);
    wait_log(0, 2, "t6b");
    expq.delete(); expq.push_back(9'h171); expq.push_back(9'h181);
    check_log(0, "t6", 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
